tds_hit_rate_monitor: RTL and testbench

//  Parametrised per-TDS hit-rate monitor on the 40 MHz domain.
//  - Masks each TDS hit vector with a shared channel select.
//  - OR-reduces each masked vector to one hit bit per TDS per cycle.
//  - Counts those hit bits over a programmable window of clk40M cycles.
//  - Snapshots all NUM_TDS counts together and hands them to the slow-control/VIO side over a ready/ack handshake.
//  - Supports single-shot and back-to-back (continuous) windows.

---
 rtl/tds_mon_pkg.sv | 19 +
 rtl/tds_hit_counter.sv | 62 ++++++
 rtl/tds_hit_rate_monitor.sv | 161 ++++++++++++++++
 tb/tb_tds_hit_rate_monitor.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tds_mon_pkg.sv
// Shared definitions for the per-TDS hit-rate monitor.
// The monitor FSM states and the default geometry of the monitored links live here.
package tds_mon_pkg;

    // Default geometry: four TDS links, 116 channels each, 20-bit counters and window.
    localparam int NUM_TDS_DEF = 4;
    localparam int HIT_W_DEF   = 116;
    localparam int CNT_W_DEF   = 20;
    localparam int WIN_W_DEF   = 20;

    // Monitor run states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_COUNT = 2'd2,
        ST_HOLD  = 2'd3
    } mon_state_e;

endpackage

// File: rtl/tds_hit_counter.sv
// One TDS lane of the hit-rate monitor.
// The lane masks its hit vector with the channel select and gates it with its TDS enable.
// It OR-reduces the result in a two-stage pipeline and feeds a saturating counter.
// The counter also keeps a sticky overflow flag for the current window.
module tds_hit_counter
    import tds_mon_pkg::*;
#(
    parameter int HIT_W = HIT_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk40M,
    input  logic             reset_n,
    input  logic [HIT_W-1:0] hit_vec_i,
    input  logic [HIT_W-1:0] chan_sel_i,
    input  logic             tds_en_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             inc_snapshot_i,
    output logic [CNT_W-1:0] count_next_o,
    output logic             ovf_o
);

    logic [HIT_W-1:0] masked_q;
    logic             hit_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             ovf_q;
    logic             sat_now;

    // A hit that arrives while the counter is already all-ones is dropped and flagged.
    assign sat_now      = (&count_q) & hit_q;
    assign count_d      = sat_now ? count_q : count_q + CNT_W'(hit_q);
    assign count_next_o = count_d;
    assign ovf_o        = ovf_q | sat_now;

    // Two-stage input pipeline: masked vector first, then the per-TDS hit bit.
    always_ff @(posedge clk40M or negedge reset_n) begin
        if (!reset_n) begin
            masked_q <= '0;
            hit_q    <= 1'b0;
        end else begin
            masked_q <= hit_vec_i & chan_sel_i & {HIT_W{tds_en_i}};
            hit_q    <= |masked_q;
        end
    end

    // The counter clears on arm and restarts on a back-to-back snapshot.
    // It accumulates only while the window is open.
    always_ff @(posedge clk40M or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else if (clr_i || inc_snapshot_i) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else if (en_i) begin
            count_q <= count_d;
            ovf_q   <= ovf_o;
        end
    end

endmodule

// File: rtl/tds_hit_rate_monitor.sv
// Per-TDS hit-rate monitor on the 40 MHz domain.
// The top holds the start-edge detect, the run FSM, the window counter and the snapshot registers.
// It also drives the ready/ack handshake towards slow control.
module tds_hit_rate_monitor
    import tds_mon_pkg::*;
#(
    parameter int NUM_TDS = NUM_TDS_DEF,
    parameter int HIT_W   = HIT_W_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int WIN_W   = WIN_W_DEF
) (
    input  logic                     clk40M,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     continuous,
    input  logic [WIN_W-1:0]         window,
    input  logic [NUM_TDS-1:0]       tds_select,
    input  logic [HIT_W-1:0]         channel_select,
    input  logic [NUM_TDS*HIT_W-1:0] hit_vec,
    input  logic                     ack,
    output logic                     busy,
    output logic                     ready,
    output logic [NUM_TDS*CNT_W-1:0] count_out,
    output logic [NUM_TDS-1:0]       overflow,
    output logic                     missed,
    output logic [7:0]               window_id
);

    mon_state_e               state_q, state_d;
    logic                     start_q;
    logic                     start_rise;
    logic [WIN_W-1:0]         win_cnt_q, win_cnt_d;
    logic [WIN_W-1:0]         win_load;
    logic                     ready_q, ready_d;
    logic                     missed_q, missed_d;
    logic [7:0]               window_id_q, window_id_d;
    logic [NUM_TDS*CNT_W-1:0] count_out_q;
    logic [NUM_TDS-1:0]       overflow_q;
    logic                     cnt_clr;
    logic                     cnt_en;
    logic                     cnt_reload;
    logic                     snap;
    logic [NUM_TDS*CNT_W-1:0] cnt_next;
    logic [NUM_TDS-1:0]       cnt_ovf;

    assign start_rise = start & ~start_q;
    assign win_load   = (window == '0) ? WIN_W'(1) : window;

    for (genvar g = 0; g < NUM_TDS; g++) begin : g_tds
        tds_hit_counter #(
            .HIT_W (HIT_W),
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk40M         (clk40M),
            .reset_n        (reset_n),
            .hit_vec_i      (hit_vec[g*HIT_W +: HIT_W]),
            .chan_sel_i     (channel_select),
            .tds_en_i       (tds_select[g]),
            .clr_i          (cnt_clr),
            .en_i           (cnt_en),
            .inc_snapshot_i (cnt_reload),
            .count_next_o   (cnt_next[g*CNT_W +: CNT_W]),
            .ovf_o          (cnt_ovf[g])
        );
    end

    // Next state, window countdown and handshake flags.
    // When a snapshot and an ack land on the same cycle, the snapshot wins.
    always_comb begin
        state_d     = state_q;
        win_cnt_d   = win_cnt_q;
        ready_d     = ready_q;
        missed_d    = missed_q;
        window_id_d = window_id_q;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
        cnt_reload  = 1'b0;
        snap        = 1'b0;

        if (ack && ready_q) begin
            ready_d  = 1'b0;
            missed_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_rise) begin
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                cnt_clr   = 1'b1;
                win_cnt_d = win_load;
                state_d   = ST_COUNT;
            end
            ST_COUNT: begin
                cnt_en    = 1'b1;
                win_cnt_d = win_cnt_q - WIN_W'(1);
                if (win_cnt_q == WIN_W'(1)) begin
                    snap        = 1'b1;
                    ready_d     = 1'b1;
                    window_id_d = window_id_q + 8'd1;
                    if (ready_q && !ack) begin
                        missed_d = 1'b1;
                    end
                    if (continuous && start) begin
                        cnt_reload = 1'b1;
                        win_cnt_d  = win_load;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (ack || !ready_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Register the FSM, the window counter, the start history and the handshake flags.
    always_ff @(posedge clk40M or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            start_q     <= 1'b0;
            win_cnt_q   <= '0;
            ready_q     <= 1'b0;
            missed_q    <= 1'b0;
            window_id_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            start_q     <= start;
            win_cnt_q   <= win_cnt_d;
            ready_q     <= ready_d;
            missed_q    <= missed_d;
            window_id_q <= window_id_d;
        end
    end

    // Capture all lanes together on the last cycle of a window.
    // The capture includes that cycle's hit.
    always_ff @(posedge clk40M or negedge reset_n) begin
        if (!reset_n) begin
            count_out_q <= '0;
            overflow_q  <= '0;
        end else if (snap) begin
            count_out_q <= cnt_next;
            overflow_q  <= cnt_ovf;
        end
    end

    assign busy      = (state_q == ST_ARM) || (state_q == ST_COUNT);
    assign ready     = ready_q;
    assign missed    = missed_q;
    assign window_id = window_id_q;
    assign count_out = count_out_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_tds_hit_rate_monitor.sv
// Testbench for tds_hit_rate_monitor.
// A cycle-level behavioural model predicts every output.
// A compare process checks the DUT against the model on each falling edge.
// Directed scenarios also pin key values with hand-computed literals.
module tb_tds_hit_rate_monitor;

    localparam int NT = 4;
    localparam int HW = 116;
    localparam int CW = 4;
    localparam int WW = 20;
    localparam int VW = NT * HW;
    localparam int CMAX = (1 << CW) - 1;

    localparam int P_IDLE  = 0;
    localparam int P_ARM   = 1;
    localparam int P_COUNT = 2;
    localparam int P_HOLD  = 3;

    logic           clk40M = 1'b0;
    logic           reset_n = 1'b0;
    logic           start = 1'b0;
    logic           continuous = 1'b0;
    logic [WW-1:0]  window = '0;
    logic [NT-1:0]  tds_select = '0;
    logic [HW-1:0]  channel_select = '0;
    logic [VW-1:0]  hit_vec = '0;
    logic           ack = 1'b0;
    logic           busy;
    logic           ready;
    logic [NT*CW-1:0] count_out;
    logic [NT-1:0]  overflow;
    logic           missed;
    logic [7:0]     window_id;

    int checks = 0;
    int failures = 0;
    bit cmpEn = 1'b0;

    tds_hit_rate_monitor #(
        .NUM_TDS (NT),
        .HIT_W   (HW),
        .CNT_W   (CW),
        .WIN_W   (WW)
    ) dut (
        .clk40M         (clk40M),
        .reset_n        (reset_n),
        .start          (start),
        .continuous     (continuous),
        .window         (window),
        .tds_select     (tds_select),
        .channel_select (channel_select),
        .hit_vec        (hit_vec),
        .ack            (ack),
        .busy           (busy),
        .ready          (ready),
        .count_out      (count_out),
        .overflow       (overflow),
        .missed         (missed),
        .window_id      (window_id)
    );

    always #5 clk40M = ~clk40M;

    // Model state.
    // Each stage holds the per-TDS hit bit after the input delay: one stage is one cycle old, the other two cycles old.
    logic [NT-1:0]    mDly1 = '0;
    logic [NT-1:0]    mDly2 = '0;
    int               mPhase = P_IDLE;
    int               mLeft = 0;
    int               mAcc [NT];
    bit               mOvf [NT];
    bit               mStartPrev = 1'b0;
    logic [NT*CW-1:0] eCount = '0;
    logic [NT-1:0]    eOvf = '0;
    bit               eReady = 1'b0;
    bit               eMissed = 1'b0;
    logic [7:0]       eWid = '0;
    bit               eBusy = 1'b0;

    // Behavioural model.
    // Hits enter a two-cycle delay line.
    // A window counts whatever emerges from the delay line on each of its COUNT cycles.
    always @(posedge clk40M or negedge reset_n) begin
        logic [NT-1:0] used;
        logic [NT-1:0] fresh;
        bit            rise;
        bit            oldReady;
        if (!reset_n) begin
            mDly1 = '0; mDly2 = '0; mPhase = P_IDLE; mLeft = 0; mStartPrev = 1'b0;
            for (int i = 0; i < NT; i++) begin mAcc[i] = 0; mOvf[i] = 1'b0; end
            eCount = '0; eOvf = '0; eReady = 1'b0; eMissed = 1'b0; eWid = '0; eBusy = 1'b0;
        end else begin
            for (int i = 0; i < NT; i++)
                fresh[i] = tds_select[i] && ((hit_vec[i*HW +: HW] & channel_select) != '0);
            used  = mDly2;
            mDly2 = mDly1;
            mDly1 = fresh;
            rise = start && !mStartPrev;
            mStartPrev = start;
            oldReady = eReady;
            if (ack && eReady) begin eReady = 1'b0; eMissed = 1'b0; end
            case (mPhase)
                P_IDLE: if (rise) mPhase = P_ARM;
                P_ARM: begin
                    for (int i = 0; i < NT; i++) begin mAcc[i] = 0; mOvf[i] = 1'b0; end
                    mLeft = (window == 0) ? 1 : int'(window);
                    mPhase = P_COUNT;
                end
                P_COUNT: begin
                    for (int i = 0; i < NT; i++)
                        if (used[i]) begin
                            if (mAcc[i] == CMAX) mOvf[i] = 1'b1;
                            else mAcc[i] = mAcc[i] + 1;
                        end
                    if (mLeft == 1) begin
                        for (int i = 0; i < NT; i++) begin
                            eCount[i*CW +: CW] = mAcc[i][CW-1:0];
                            eOvf[i] = mOvf[i];
                        end
                        eReady = 1'b1;
                        if (oldReady && !ack) eMissed = 1'b1;
                        eWid = eWid + 8'd1;
                        if (continuous && start) begin
                            for (int i = 0; i < NT; i++) begin mAcc[i] = 0; mOvf[i] = 1'b0; end
                            mLeft = (window == 0) ? 1 : int'(window);
                        end else begin
                            mPhase = P_HOLD;
                        end
                    end else begin
                        mLeft = mLeft - 1;
                    end
                end
                default: if (ack || !oldReady) mPhase = P_IDLE;
            endcase
            eBusy = (mPhase == P_ARM) || (mPhase == P_COUNT);
        end
    end

    // Compare one DUT value against its expectation and count the outcome.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // On every falling edge, check all DUT outputs against the model.
    always @(negedge clk40M) begin
        if (cmpEn) begin
            checkOutput("model count_out", 32'(count_out), 32'(eCount));
            checkOutput("model overflow", 32'(overflow), 32'(eOvf));
            checkOutput("model ready", 32'(ready), 32'(eReady));
            checkOutput("model missed", 32'(missed), 32'(eMissed));
            checkOutput("model window_id", 32'(window_id), 32'(eWid));
            checkOutput("model busy", 32'(busy), 32'(eBusy));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk40M);
            #1;
        end
    endtask

    function automatic logic [VW-1:0] hitAt(input int tds, input int b);
        logic [VW-1:0] v;
        v = '0;
        v[tds*HW + b] = 1'b1;
        return v;
    endfunction

    // Drive a hit pattern for n cycles: vecA on even cycles, vecB on odd cycles.
    task automatic applyStimulus(input int n, input logic [VW-1:0] vecA, input logic [VW-1:0] vecB);
        for (int c = 0; c < n; c++) begin
            hit_vec = (c % 2 == 0) ? vecA : vecB;
            tick(1);
        end
    endtask

    // Acknowledge the pending result and return to idle with start low.
    task automatic releaseResult();
        ack = 1'b1;
        start = 1'b0;
        hit_vec = '0;
        tick(1);
        ack = 1'b0;
        tick(2);
    endtask

    initial begin
        logic [VW-1:0] allHits;
        logic [HW-1:0] onlyBit5;
        allHits = hitAt(0, 0) | hitAt(1, 0) | hitAt(2, 0) | hitAt(3, 0);
        onlyBit5 = '0;
        onlyBit5[5] = 1'b1;

        // Reset state.
        tick(3);
        cmpEn = 1'b1;
        checkOutput("reset ready", 32'(ready), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset count_out", 32'(count_out), 32'd0);
        checkOutput("reset window_id", 32'(window_id), 32'd0);
        checkOutput("reset missed", 32'(missed), 32'd0);
        checkOutput("reset overflow", 32'(overflow), 32'd0);
        reset_n = 1'b1;
        tick(1);

        // T1: single shot, window 10; TDS0 hits every cycle and TDS1 every second cycle.
        tds_select = 4'hF; channel_select = '1; window = 20'd10; continuous = 1'b0;
        start = 1'b1;
        applyStimulus(11, hitAt(0, 3) | hitAt(1, 10), hitAt(0, 3));
        checkOutput("T1 ready not yet", 32'(ready), 32'd0);
        applyStimulus(1, '0, '0);
        checkOutput("T1 ready", 32'(ready), 32'd1);
        checkOutput("T1 count_out", 32'(count_out), 32'h005A);
        checkOutput("T1 window_id", 32'(window_id), 32'd1);
        checkOutput("T1 busy", 32'(busy), 32'd0);
        releaseResult();
        checkOutput("T1 ready after ack", 32'(ready), 32'd0);

        // T2: masking; only channel 5 and only TDS0 are enabled.
        channel_select = onlyBit5; tds_select = 4'b0001;
        start = 1'b1;
        applyStimulus(12, hitAt(0, 7) | hitAt(2, 5), hitAt(0, 7) | hitAt(2, 5));
        checkOutput("T2 masked counts", 32'(count_out), 32'h0000);
        releaseResult();
        start = 1'b1;
        applyStimulus(3, hitAt(0, 5), hitAt(0, 5));
        applyStimulus(9, '0, '0);
        checkOutput("T2 count0", 32'(count_out), 32'h0003);
        checkOutput("T2 window_id", 32'(window_id), 32'd3);
        releaseResult();

        // T3: saturation of a 4-bit counter over a 20-cycle window.
        channel_select = '1; tds_select = 4'hF; window = 20'd20;
        start = 1'b1;
        applyStimulus(22, hitAt(0, 0), hitAt(0, 0));
        checkOutput("T3 count0", 32'(count_out), 32'h000F);
        checkOutput("T3 overflow", 32'(overflow), 32'h1);
        releaseResult();

        // T4/T5: continuous 4-cycle windows with window_id wrap, ack on a snapshot, then stop.
        window = 20'd4; continuous = 1'b1; hit_vec = allHits;
        start = 1'b1;
        for (int n = 0; n <= 1020; n++) begin
            if (n == 1013) ack = 1'b1;
            if (n == 1014) ack = 1'b0;
            if (n == 1015) start = 1'b0;
            tick(1);
            if (n == 5) begin
                checkOutput("T4 first counts", 32'(count_out), 32'h4444);
                checkOutput("T4 first missed", 32'(missed), 32'd0);
                checkOutput("T4 first window_id", 32'(window_id), 32'd5);
            end
            if (n == 9) begin
                checkOutput("T4 second missed", 32'(missed), 32'd1);
                checkOutput("T4 second window_id", 32'(window_id), 32'd6);
            end
            if (n == 1008) checkOutput("T4 window_id 255", 32'(window_id), 32'd255);
            if (n == 1009) checkOutput("T4 window_id wrap", 32'(window_id), 32'd0);
            if (n == 1013) begin
                checkOutput("T5 ack+snapshot ready", 32'(ready), 32'd1);
                checkOutput("T5 ack+snapshot missed", 32'(missed), 32'd0);
            end
            if (n == 1017) checkOutput("T4 stop busy", 32'(busy), 32'd0);
        end
        releaseResult();

        // T5: window 0 behaves as 1-cycle windows.
        window = 20'd0; continuous = 1'b1; hit_vec = allHits;
        start = 1'b1;
        tick(3);
        checkOutput("T5 win0 counts", 32'(count_out), 32'h1111);
        checkOutput("T5 win0 window_id", 32'(window_id), 32'd3);
        tick(1);
        checkOutput("T5 win0 next window_id", 32'(window_id), 32'd4);
        start = 1'b0;
        tick(1);
        checkOutput("T5 win0 stop busy", 32'(busy), 32'd0);
        releaseResult();

        // T6: reset asserted mid-COUNT, then a fresh run.
        window = 20'd10; continuous = 1'b0; hit_vec = allHits;
        start = 1'b1;
        tick(5);
        start = 1'b0;
        reset_n = 1'b0;
        #1;
        checkOutput("T6 reset busy", 32'(busy), 32'd0);
        checkOutput("T6 reset count_out", 32'(count_out), 32'd0);
        checkOutput("T6 reset window_id", 32'(window_id), 32'd0);
        tick(2);
        reset_n = 1'b1;
        tick(1);
        window = 20'd4;
        start = 1'b1;
        tick(6);
        checkOutput("T6 rerun counts", 32'(count_out), 32'h4444);
        checkOutput("T6 rerun window_id", 32'(window_id), 32'd1);
        checkOutput("T6 rerun ready", 32'(ready), 32'd1);
        releaseResult();

        cmpEn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
